// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU and its command sequencer:
// opcode encoding (must match the ALU's S input), data width and the
// sequencer state type.
package alu_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_XOR  = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_NOR  = 3'd4;
   localparam logic [2:0] ALU_SHR  = 3'd5;
   localparam logic [2:0] ALU_SHL  = 3'd6;
   localparam logic [2:0] ALU_RSVD = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_RESP  = 2'd3
   } ctrl_state_e;

   // True for the 1-bit shift opcodes that the sequencer iterates.
   function automatic logic is_shift(input logic [2:0] op);
      return (op == ALU_SHR) || (op == ALU_SHL);
   endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU. Shifts move by one bit; CO is the add carry-out,
// or bit 31 of in1 for shl (the bit shifted out), and 0 otherwise.
module alu
   import alu_pkg::*;
(
   input  logic [2:0]        S,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   output logic [DATA_W-1:0] out,
   output logic              CO
);

   logic [DATA_W:0] sum;

   assign sum = {1'b0, in1} + {1'b0, in2};

   // Select the result and carry for the requested operation.
   always_comb begin
      out = '0;
      CO  = 1'b0;
      case (S)
         ALU_ADD: begin
            out = sum[DATA_W-1:0];
            CO  = sum[DATA_W];
         end
         ALU_XOR: out = in1 ^ in2;
         ALU_AND: out = in1 & in2;
         ALU_OR:  out = in1 | in2;
         ALU_NOR: out = ~(in1 | in2);
         ALU_SHR: out = {1'b0, in1[DATA_W-1:1]};
         ALU_SHL: begin
            out = {in1[DATA_W-2:0], 1'b0};
            CO  = in1[DATA_W-1];
         end
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_ctrl.sv
// Command sequencer for the 32-bit ALU. Accepts one command at a time,
// drives the ALU for one cycle (logic/add ops) or iterates its 1-bit shift
// (shr/shl by shamt), and holds a registered response until consumed.
// All outputs come from registers or a decode of the current state.
module alu_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [DATA_W-1:0]  cmd_a,
   input  logic [DATA_W-1:0]  cmd_b,
   input  logic [SHAMT_W-1:0] cmd_shamt,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_co,
   output logic               rsp_err,
   output logic [2:0]         alu_s,
   output logic [DATA_W-1:0]  alu_in1,
   output logic [DATA_W-1:0]  alu_in2,
   input  logic [DATA_W-1:0]  alu_out,
   input  logic               alu_co
);

   ctrl_state_e        state_q, state_d;
   logic [2:0]         op_q;
   logic [DATA_W-1:0]  a_q;
   logic [DATA_W-1:0]  b_q;
   logic [DATA_W-1:0]  acc_q;
   logic [SHAMT_W-1:0] count_q;
   logic [DATA_W-1:0]  data_q;
   logic               co_q;
   logic               err_q;
   logic               last_shift;

   assign last_shift = (count_q == SHAMT_W'(1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: dispatch by opcode at acceptance, then step to RESP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op == ALU_RSVD)
                  state_d = ST_RESP;
               else if (is_shift(cmd_op))
                  state_d = (cmd_shamt == '0) ? ST_RESP : ST_SHIFT;
               else
                  state_d = ST_EXEC;
            end
         end
         ST_EXEC:  state_d = ST_RESP;
         ST_SHIFT: if (last_shift) state_d = ST_RESP;
         ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Command capture, shift iteration and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         count_q <= '0;
         data_q  <= '0;
         co_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  a_q     <= cmd_a;
                  b_q     <= cmd_b;
                  acc_q   <= cmd_a;
                  count_q <= cmd_shamt;
                  co_q    <= 1'b0;
                  err_q   <= (cmd_op == ALU_RSVD);
                  // Zero-length shift completes immediately with the source.
                  if (is_shift(cmd_op) && (cmd_shamt == '0))
                     data_q <= cmd_a;
                  else
                     data_q <= '0;
               end
            end
            ST_EXEC: begin
               data_q <= alu_out;
               co_q   <= alu_co;
            end
            ST_SHIFT: begin
               acc_q   <= alu_out;
               count_q <= count_q - 1'b1;
               if (last_shift) begin
                  data_q <= alu_out;
                  co_q   <= alu_co;
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake and ALU drive decoded from state and held registers.
   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
      rsp_data  = data_q;
      rsp_co    = co_q;
      rsp_err   = err_q;
      alu_s     = '0;
      alu_in1   = '0;
      alu_in2   = '0;
      case (state_q)
         ST_EXEC: begin
            alu_s   = op_q;
            alu_in1 = a_q;
            alu_in2 = b_q;
         end
         ST_SHIFT: begin
            alu_s   = op_q;
            alu_in1 = acc_q;
         end
         default: ;
      endcase
   end

endmodule
